// File: rtl/tlb_param.sv
// rtl/tlb_param.sv - parametrised fully associative joint TLB with IF/MEM ports and CP0 services
module tlb_param #(
  parameter int TLBNUM = 16,
  parameter int IDX_W  = $clog2(TLBNUM),
  parameter int ASID_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_en,
  input  logic [31:0]       i_vaddr,
  output logic [31:0]       i_paddr,
  output logic              i_uncached,
  output logic              i_refill,
  output logic              i_invalid,
  input  logic              d_en,
  input  logic [31:0]       d_vaddr,
  input  logic              d_store,
  output logic [31:0]       d_paddr,
  output logic              d_uncached,
  output logic              d_refill,
  output logic              d_invalid,
  output logic              d_modified,
  input  logic [18:0]       cp0_vpn2,
  input  logic [ASID_W-1:0] cp0_asid,
  input  logic [19:0]       cp0_pfn0,
  input  logic [2:0]        cp0_c0,
  input  logic              cp0_d0,
  input  logic              cp0_v0,
  input  logic              cp0_g0,
  input  logic [19:0]       cp0_pfn1,
  input  logic [2:0]        cp0_c1,
  input  logic              cp0_d1,
  input  logic              cp0_v1,
  input  logic              cp0_g1,
  input  logic [IDX_W-1:0]  cp0_index,
  input  logic [IDX_W-1:0]  cp0_wired,
  input  logic              wired_we,
  input  logic              tlbwi,
  input  logic              tlbwr,
  input  logic              tlbp,
  input  logic              tlbr,
  output logic              probe_valid,
  output logic              probe_miss,
  output logic [IDX_W-1:0]  probe_index,
  output logic              rd_valid,
  output logic [18:0]       mmu_vpn2,
  output logic [ASID_W-1:0] mmu_asid,
  output logic [19:0]       mmu_pfn0,
  output logic [2:0]        mmu_c0,
  output logic              mmu_d0,
  output logic              mmu_v0,
  output logic              mmu_g0,
  output logic [19:0]       mmu_pfn1,
  output logic [2:0]        mmu_c1,
  output logic              mmu_d1,
  output logic              mmu_v1,
  output logic              mmu_g1,
  output logic [IDX_W-1:0]  random
);

  localparam logic [IDX_W-1:0] RAND_MAX = IDX_W'(TLBNUM - 1);

  typedef struct packed {
    logic [31:0] paddr;
    logic        uncached;
    logic        refill;
    logic        invalid;
    logic        modified;
  } xlat_t;

  logic [18:0]       e_vpn2 [TLBNUM];
  logic [ASID_W-1:0] e_asid [TLBNUM];
  logic [19:0]       e_pfn0 [TLBNUM];
  logic [19:0]       e_pfn1 [TLBNUM];
  logic [2:0]        e_c0   [TLBNUM];
  logic [2:0]        e_c1   [TLBNUM];
  logic [TLBNUM-1:0] e_d0, e_d1, e_v0, e_v1, e_g, e_used;

  logic              we;
  logic [IDX_W-1:0]  widx;
  logic [IDX_W:0]    probe_hit;
  xlat_t             i_res, d_res;

  // Entries never written since reset carry stale tags and must not match.
  function automatic logic [IDX_W:0] find(input logic [18:0] vpn, input logic [ASID_W-1:0] as);
    logic [IDX_W:0] r;
    r = '0;
    for (int i = TLBNUM - 1; i >= 0; i--)
      if (e_used[i] && e_vpn2[i] == vpn && (e_g[i] || e_asid[i] == as))
        r = {1'b1, IDX_W'(i)};
    return r;
  endfunction

  function automatic xlat_t xlate(input logic [31:0] va, input logic store);
    xlat_t          r;
    logic [IDX_W:0] m;
    logic [IDX_W-1:0] k;
    logic [19:0]    pfn;
    logic [2:0]     c;
    logic           v, d;
    r = '0;
    if (va[31:30] == 2'b10) begin
      r.paddr    = {3'b000, va[28:0]};
      r.uncached = va[29];
    end else begin
      m   = find(va[31:13], cp0_asid);
      k   = m[IDX_W-1:0];
      pfn = va[12] ? e_pfn1[k] : e_pfn0[k];
      c   = va[12] ? e_c1[k]   : e_c0[k];
      v   = va[12] ? e_v1[k]   : e_v0[k];
      d   = va[12] ? e_d1[k]   : e_d0[k];
      r.refill   = !m[IDX_W];
      r.invalid  = m[IDX_W] && !v;
      r.modified = m[IDX_W] && v && !d && store;
      r.uncached = m[IDX_W] && (c != 3'd3);
      r.paddr    = (r.refill || r.invalid || r.modified) ? 32'h0 : {pfn, va[11:0]};
    end
    return r;
  endfunction

  always_comb begin
    we        = tlbwi | tlbwr;
    widx      = tlbwi ? cp0_index : random;
    i_res     = xlate(i_vaddr, 1'b0);
    d_res     = xlate(d_vaddr, d_store);
    probe_hit = find(cp0_vpn2, cp0_asid);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      e_used <= '0;
      e_g    <= '0;
      e_v0   <= '0;
      e_v1   <= '0;
    end else if (we) begin
      e_used[widx] <= 1'b1;
      e_g[widx]    <= cp0_g0 & cp0_g1;
      e_v0[widx]   <= cp0_v0;
      e_v1[widx]   <= cp0_v1;
    end
  end

  always_ff @(posedge clk) begin
    if (we) begin
      e_vpn2[widx] <= cp0_vpn2;
      e_asid[widx] <= cp0_asid;
      e_pfn0[widx] <= cp0_pfn0;
      e_pfn1[widx] <= cp0_pfn1;
      e_c0[widx]   <= cp0_c0;
      e_c1[widx]   <= cp0_c1;
      e_d0[widx]   <= cp0_d0;
      e_d1[widx]   <= cp0_d1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      {i_paddr, i_uncached, i_refill, i_invalid} <= '0;
      {d_paddr, d_uncached, d_refill, d_invalid, d_modified} <= '0;
    end else begin
      if (i_en)
        {i_paddr, i_uncached, i_refill, i_invalid} <=
          {i_res.paddr, i_res.uncached, i_res.refill, i_res.invalid};
      if (d_en)
        {d_paddr, d_uncached, d_refill, d_invalid, d_modified} <= d_res;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      probe_valid <= 1'b0;
      probe_miss  <= 1'b0;
      probe_index <= '0;
      rd_valid    <= 1'b0;
      {mmu_vpn2, mmu_asid, mmu_pfn0, mmu_c0, mmu_d0, mmu_v0, mmu_g0} <= '0;
      {mmu_pfn1, mmu_c1, mmu_d1, mmu_v1, mmu_g1} <= '0;
    end else begin
      probe_valid <= tlbp;
      rd_valid    <= tlbr;
      if (tlbp) begin
        probe_miss  <= !probe_hit[IDX_W];
        probe_index <= probe_hit[IDX_W-1:0];
      end
      if (tlbr) begin
        mmu_vpn2 <= e_vpn2[cp0_index];
        mmu_asid <= e_asid[cp0_index];
        mmu_pfn0 <= e_pfn0[cp0_index];
        mmu_c0   <= e_c0[cp0_index];
        mmu_d0   <= e_d0[cp0_index];
        mmu_v0   <= e_v0[cp0_index];
        mmu_g0   <= e_g[cp0_index];
        mmu_pfn1 <= e_pfn1[cp0_index];
        mmu_c1   <= e_c1[cp0_index];
        mmu_d1   <= e_d1[cp0_index];
        mmu_v1   <= e_v1[cp0_index];
        mmu_g1   <= e_g[cp0_index];
      end
    end
  end

  // Random wraps to the top once it reaches the wired boundary.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      random <= RAND_MAX;
    else if (wired_we || random <= cp0_wired)
      random <= RAND_MAX;
    else
      random <= random - 1'b1;
  end

endmodule

// File: tb/tb_tlb_param.sv
// tb/tb_tlb_param.sv - directed self-checking bench for tlb_param
module tb_tlb_param;

  logic        clk, rst;
  logic        i_en, d_en, d_store;
  logic [31:0] i_vaddr, d_vaddr, i_paddr, d_paddr;
  logic        i_uncached, i_refill, i_invalid;
  logic        d_uncached, d_refill, d_invalid, d_modified;
  logic [18:0] cp0_vpn2, mmu_vpn2;
  logic [7:0]  cp0_asid, mmu_asid;
  logic [19:0] cp0_pfn0, cp0_pfn1, mmu_pfn0, mmu_pfn1;
  logic [2:0]  cp0_c0, cp0_c1, mmu_c0, mmu_c1;
  logic        cp0_d0, cp0_v0, cp0_g0, cp0_d1, cp0_v1, cp0_g1;
  logic        mmu_d0, mmu_v0, mmu_g0, mmu_d1, mmu_v1, mmu_g1;
  logic [3:0]  cp0_index, cp0_wired, probe_index, random;
  logic        wired_we, tlbwi, tlbwr, tlbp, tlbr;
  logic        probe_valid, probe_miss, rd_valid;

  int n_checks = 0;
  int n_fail   = 0;

  tlb_param dut (
    .clk(clk), .rst(rst),
    .i_en(i_en), .i_vaddr(i_vaddr), .i_paddr(i_paddr), .i_uncached(i_uncached),
    .i_refill(i_refill), .i_invalid(i_invalid),
    .d_en(d_en), .d_vaddr(d_vaddr), .d_store(d_store), .d_paddr(d_paddr),
    .d_uncached(d_uncached), .d_refill(d_refill), .d_invalid(d_invalid), .d_modified(d_modified),
    .cp0_vpn2(cp0_vpn2), .cp0_asid(cp0_asid),
    .cp0_pfn0(cp0_pfn0), .cp0_c0(cp0_c0), .cp0_d0(cp0_d0), .cp0_v0(cp0_v0), .cp0_g0(cp0_g0),
    .cp0_pfn1(cp0_pfn1), .cp0_c1(cp0_c1), .cp0_d1(cp0_d1), .cp0_v1(cp0_v1), .cp0_g1(cp0_g1),
    .cp0_index(cp0_index), .cp0_wired(cp0_wired), .wired_we(wired_we),
    .tlbwi(tlbwi), .tlbwr(tlbwr), .tlbp(tlbp), .tlbr(tlbr),
    .probe_valid(probe_valid), .probe_miss(probe_miss), .probe_index(probe_index),
    .rd_valid(rd_valid),
    .mmu_vpn2(mmu_vpn2), .mmu_asid(mmu_asid),
    .mmu_pfn0(mmu_pfn0), .mmu_c0(mmu_c0), .mmu_d0(mmu_d0), .mmu_v0(mmu_v0), .mmu_g0(mmu_g0),
    .mmu_pfn1(mmu_pfn1), .mmu_c1(mmu_c1), .mmu_d1(mmu_d1), .mmu_v1(mmu_v1), .mmu_g1(mmu_g1),
    .random(random)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_entry(input logic [18:0] vpn2, input logic [7:0] asid, input logic g,
                           input logic [19:0] pfn0, input logic [2:0] c0, input logic d0, input logic v0,
                           input logic [19:0] pfn1, input logic [2:0] c1, input logic d1, input logic v1);
    cp0_vpn2 = vpn2; cp0_asid = asid; cp0_g0 = g; cp0_g1 = g;
    cp0_pfn0 = pfn0; cp0_c0 = c0; cp0_d0 = d0; cp0_v0 = v0;
    cp0_pfn1 = pfn1; cp0_c1 = c1; cp0_d1 = d1; cp0_v1 = v1;
  endtask

  initial begin
    rst = 1'b1;
    {i_en, d_en, d_store, wired_we, tlbwi, tlbwr, tlbp, tlbr} = '0;
    i_vaddr = '0; d_vaddr = '0; cp0_index = '0; cp0_wired = '0;
    set_entry('0, '0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
    #12;
    check("rst_i_paddr", i_paddr, 32'h0);
    check("rst_random", {28'h0, random}, 32'd15);
    check("rst_probe_valid", {31'h0, probe_valid}, 32'h0);
    rst = 1'b0;

    // Random free-runs 14..0 then wraps to 15 with Wired = 0
    for (int k = 1; k <= 16; k++) begin
      tick();
      check("rand_run", {28'h0, random}, (k == 16) ? 32'd15 : 32'(15 - k));
    end

    // Kseg1 / kseg0 unmapped translation
    i_en = 1'b1; d_en = 1'b1;
    i_vaddr = 32'hBFC0_0000; d_vaddr = 32'h8000_1234;
    tick();
    check("kseg1_paddr", i_paddr, 32'h1FC0_0000);
    check("kseg1_unc", {31'h0, i_uncached}, 32'h1);
    check("kseg1_exc", {30'h0, i_refill, i_invalid}, 32'h0);
    check("kseg0_paddr", d_paddr, 32'h0000_1234);
    check("kseg0_unc", {31'h0, d_uncached}, 32'h0);

    // TLBWI index 3; lookup in the write cycle sees the empty TLB
    set_entry(19'h00010, 8'd5, 1'b0, 20'h0ABCD, 3'd2, 1'b1, 1'b0, 20'h12345, 3'd3, 1'b0, 1'b1);
    cp0_index = 4'd3; tlbwi = 1'b1;
    d_vaddr = 32'h0002_1ABC; d_store = 1'b1;
    tick();
    tlbwi = 1'b0;
    check("pre_write_refill", {31'h0, d_refill}, 32'h1);
    tick();
    check("store_modified", {31'h0, d_modified}, 32'h1);
    check("store_paddr", d_paddr, 32'h0);
    check("store_refill", {31'h0, d_refill}, 32'h0);
    d_store = 1'b0;
    tick();
    check("load_paddr", d_paddr, 32'h1234_5ABC);
    check("load_unc", {31'h0, d_uncached}, 32'h0);
    check("load_modified", {31'h0, d_modified}, 32'h0);

    // Invalid even page on the instruction port, then ASID mismatch
    i_vaddr = 32'h0002_0ABC;
    tick();
    check("even_invalid", {31'h0, i_invalid}, 32'h1);
    check("even_refill", {31'h0, i_refill}, 32'h0);
    check("even_paddr", i_paddr, 32'h0);
    cp0_asid = 8'd6;
    tick();
    check("asid_refill", {31'h0, d_refill}, 32'h1);
    check("asid_paddr", d_paddr, 32'h0);

    // TLBP hit and miss
    cp0_asid = 8'd5; tlbp = 1'b1;
    tick();
    tlbp = 1'b0;
    check("probe_valid", {31'h0, probe_valid}, 32'h1);
    check("probe_miss0", {31'h0, probe_miss}, 32'h0);
    check("probe_index", {28'h0, probe_index}, 32'd3);
    tick();
    check("probe_pulse", {31'h0, probe_valid}, 32'h0);
    cp0_vpn2 = 19'h7FFFF; tlbp = 1'b1;
    tick();
    tlbp = 1'b0;
    check("probe_miss1", {31'h0, probe_miss}, 32'h1);

    // TLBR of entry 3
    tlbr = 1'b1;
    tick();
    tlbr = 1'b0;
    check("rd_valid", {31'h0, rd_valid}, 32'h1);
    check("rd_vpn2", {13'h0, mmu_vpn2}, 32'h10);
    check("rd_pfn1", {12'h0, mmu_pfn1}, 32'h12345);
    check("rd_asid_g", {23'h0, mmu_asid, mmu_g0}, {23'h0, 8'd5, 1'b0});

    // Wired = 4: 15, 14 .. 4, 15
    cp0_wired = 4'd4; wired_we = 1'b1;
    tick();
    wired_we = 1'b0;
    check("wired_load", {28'h0, random}, 32'd15);
    for (int k = 1; k <= 12; k++) begin
      tick();
      check("wired_run", {28'h0, random}, (k == 12) ? 32'd15 : 32'(15 - k));
    end
    cp0_wired = 4'd15;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("wired_max", {28'h0, random}, 32'd15);
    end

    // TLBWR at random = 9 with a global entry
    cp0_wired = 4'd4; wired_we = 1'b1;
    tick();
    wired_we = 1'b0;
    repeat (6) tick();
    check("rand_at9", {28'h0, random}, 32'd9);
    set_entry(19'h00020, 8'd7, 1'b1, 20'h0BEEF, 3'd3, 1'b1, 1'b1, 20'h0, 3'd0, 1'b0, 1'b0);
    tlbwr = 1'b1;
    tick();
    tlbwr = 1'b0;
    check("rand_after_wr", {28'h0, random}, 32'd8);
    cp0_index = 4'd9; tlbr = 1'b1;
    cp0_asid = 8'd6; d_vaddr = 32'h0004_0123;
    tick();
    tlbr = 1'b0;
    check("wr_rd_vpn2", {13'h0, mmu_vpn2}, 32'h20);
    check("wr_rd_g1", {31'h0, mmu_g1}, 32'h1);
    check("global_paddr", d_paddr, 32'h0BEE_F123);

    // Duplicate global entry at index 2: lowest index wins
    set_entry(19'h00020, 8'd1, 1'b1, 20'h0CAFE, 3'd2, 1'b1, 1'b1, 20'h0, 3'd0, 1'b0, 1'b0);
    cp0_index = 4'd2; tlbwi = 1'b1;
    tick();
    tlbwi = 1'b0; tlbp = 1'b1;
    tick();
    tlbp = 1'b0;
    check("dup_paddr", d_paddr, 32'h0CAF_E123);
    check("dup_unc", {31'h0, d_uncached}, 32'h1);
    check("dup_probe", {28'h0, probe_index}, 32'd2);

    // Stall hold, then asynchronous reset between edges
    cp0_asid = 8'd5; i_vaddr = 32'h0002_1ABC;
    tick();
    check("hold_pre", i_paddr, 32'h1234_5ABC);
    i_en = 1'b0; i_vaddr = 32'h8000_0000;
    tick();
    check("hold_paddr", i_paddr, 32'h1234_5ABC);
    tlbp = 1'b1;
    #2 rst = 1'b1;
    #1;
    check("arst_i_paddr", i_paddr, 32'h0);
    check("arst_random", {28'h0, random}, 32'd15);
    tick();
    check("arst_probe", {31'h0, probe_valid}, 32'h0);
    tlbp = 1'b0; rst = 1'b0;
    i_en = 1'b1; i_vaddr = 32'h0002_1ABC;
    tick();
    check("arst_refill", {31'h0, i_refill}, 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: got no completion expected completion");
    $fatal(1);
  end

endmodule
